// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: operand width, iteration count,
// FSM state encoding and the divide-by-zero quotient value.
package div_pkg;

  localparam int DIV_W    = 16;
  localparam int DIV_ITER = 16;
  localparam int CNT_W    = $clog2(DIV_ITER);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_ITER - 1);
  localparam logic [DIV_W-1:0] DIV0_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/sub16pre.sv
// 17-bit adder with carry-in fixed at 1 (sum = a + b + 1), built from four
// 4-bit carry-lookahead blocks plus a final ripple bit for bit 16.
module sub16pre (
  input  logic [16:0] a,
  input  logic [16:0] b,
  output logic [16:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [4:0]  bc;

  assign g     = a[15:0] & b[15:0];
  assign p     = a[15:0] ^ b[15:0];
  assign bc[0] = 1'b1;

  for (genvar k = 0; k < 4; k++) begin : gen_cla
    localparam int B = 4 * k;

    assign c[B]     = bc[k];
    assign c[B+1]   = g[B] | (p[B] & bc[k]);
    assign c[B+2]   = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & bc[k]);
    assign c[B+3]   = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & bc[k]);
    assign bc[k+1]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B])
                    | ((&p[B+3:B]) & bc[k]);
  end

  assign sum[15:0] = p ^ c;
  assign sum[16]   = a[16] ^ b[16] ^ bc[4];

endmodule

// File: rtl/div16seq.sv
// Sequential 16-bit unsigned restoring divider: one quotient bit per cycle using
// sub16pre as the trial subtractor, with a start/busy/done handshake.
module div16seq
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div0
);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [DIV_W-1:0] q_reg;
  logic [DIV_W-1:0] r_reg;
  logic [DIV_W-1:0] d_reg;
  logic [CNT_W-1:0] cnt;
  logic             div0_reg;

  logic [DIV_W:0]   r_shift;
  logic [DIV_W:0]   sub_b;
  logic [DIV_W:0]   trial;

  // a + ~{0,D} + 1 is R' - D modulo 2^17, so trial[16] is the exact sign bit.
  assign r_shift = {r_reg, q_reg[DIV_W-1]};
  assign sub_b   = ~{1'b0, d_reg};

  sub16pre u_trial (
    .a   (r_shift),
    .b   (sub_b),
    .sum (trial)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment at the top keeps state_nxt driven on every
  // path, so no latch is inferred for unlisted cases.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg    <= '0;
      r_reg    <= '0;
      d_reg    <= '0;
      cnt      <= '0;
      div0_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              q_reg    <= DIV0_QUOT;
              r_reg    <= dividend;
              div0_reg <= 1'b1;
            end else begin
              q_reg    <= dividend;
              r_reg    <= '0;
              d_reg    <= divisor;
              cnt      <= '0;
              div0_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          // Restore by keeping the shifted remainder when the trial went negative.
          if (!trial[DIV_W]) begin
            r_reg <= trial[DIV_W-1:0];
            q_reg <= {q_reg[DIV_W-2:0], 1'b1};
          end else begin
            r_reg <= r_shift[DIV_W-1:0];
            q_reg <= {q_reg[DIV_W-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    quotient  = q_reg;
    remainder = r_reg;
    div0      = div0_reg;
  end

endmodule

// File: tb/tb_div16seq.sv
// Scoreboard bench for div16seq: stimulus pushes expected results, a monitor
// pops and compares them on every done pulse.
module tb_div16seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  div16seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("quotient[%0d]", n_done), 32'(quotient), 32'(e.q));
        check($sformatf("remainder[%0d]", n_done), 32'(remainder), 32'(e.r));
        check($sformatf("div0[%0d]", n_done), 32'(div0), 32'(e.z));
      end
      n_done++;
    end
  end

  // Waits for idle, presents one request for one cycle; returns at the negedge after E0.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r,
                       input logic z, input bit push);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("issue_timeout", 32'd1, 32'd0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back('{q: q, r: r, z: z});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int   n;
    int   done_at;
    int   guard;

    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, q: 16'hFFFF, r: 16'd0};
    vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, q: 16'd1,    r: 16'd0};
    vecs[2] = '{a: 16'd5,    b: 16'd9,    q: 16'd0,    r: 16'd5};
    vecs[3] = '{a: 16'd0,    b: 16'd3,    q: 16'd0,    r: 16'd0};
    vecs[4] = '{a: 16'd40000, b: 16'd300, q: 16'd133,  r: 16'd100};
    vecs[5] = '{a: 16'd65535, b: 16'd256, q: 16'd255,  r: 16'd255};

    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div0", 32'(div0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 100/7: done after E16, busy for exactly 17 cycles.
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    n = 1;
    done_at = 0;
    while (busy && n < 100) begin
      if (done) done_at = n;
      @(negedge clk);
      n++;
    end
    check("busy_cycles", 32'(n - 1), 32'd17);
    check("done_cycle", 32'(done_at), 32'd17);

    foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0, 1'b1);

    // Divide by zero goes straight to DONE.
    issue(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b1);
    check("div0_done_after_e0", 32'(done), 32'd1);
    @(negedge clk);
    check("div0_idle_at_e1", 32'(busy), 32'd0);

    // Starts at E5 and during DONE must be ignored.
    issue(16'd60000, 16'd250, 16'd240, 16'd0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    dividend = 16'd7;
    divisor  = 16'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("wait_done_timeout", 32'd1, 32'd0);
    dividend = 16'd9;
    divisor  = 16'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 32'(busy), 32'd0);

    // Back-to-back requests: second is accepted as soon as busy drops.
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    issue(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 1'b1);

    // Reset asserted at E8 aborts the run with no done.
    issue(16'd50000, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_div0", 32'(div0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 1'b1);

    // Random sweep against a division model.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom_range(0, 65535));
      if (i % 50 == 0)     b = 16'd0;
      else if (i % 3 == 0) b = 16'($urandom_range(1, 255));
      else                 b = 16'($urandom_range(1, 65535));
      if (b == 16'd0) issue(a, b, 16'hFFFF, a, 1'b1, 1'b1);
      else            issue(a, b, a / b, a % b, 1'b0, 1'b1);
    end

    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
